// File: rtl/fir3_mac.sv
// Three-tap FIR with a single shared multiplier: one accepted sample yields one
// result after three multiply-accumulate cycles.
module fir3_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 12,
  parameter int ACC_W  = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3*COEF_W-1:0]   coeffs,
  input  logic                  clear,
  input  logic [DATA_W-1:0]     sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic [ACC_W-1:0]      result,
  output logic                  result_valid,
  input  logic                  out_ready
);

  localparam int PROD_W = DATA_W + COEF_W;

  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, DONE} state_t;

  state_t                    state;
  logic signed [DATA_W-1:0]  x0, x1, x2;
  logic [3*COEF_W-1:0]       coef_q;
  logic signed [ACC_W-1:0]   acc;
  logic signed [DATA_W-1:0]  mul_x;
  logic signed [COEF_W-1:0]  mul_c;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_next;

  // Operand select for the shared multiplier; the MAC state picks the tap.
  always_comb begin
    mul_x = x0;
    mul_c = coef_q[COEF_W-1:0];
    case (state)
      MAC1: begin
        mul_x = x1;
        mul_c = coef_q[2*COEF_W-1:COEF_W];
      end
      MAC2: begin
        mul_x = x2;
        mul_c = coef_q[3*COEF_W-1:2*COEF_W];
      end
      default: ;
    endcase
  end

  assign prod     = mul_x * mul_c;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign acc_next = acc + prod_ext;

  // Handshakes: a sample transfers on an edge where sample_valid && sample_ready;
  // a result transfers on an edge where result_valid && out_ready. Neither side
  // may retract valid before its transfer.
  assign sample_ready = (state == IDLE) && !rst && !clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      x0           <= '0;
      x1           <= '0;
      x2           <= '0;
      coef_q       <= '0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      state        <= IDLE;
    end else if (clear) begin
      x0           <= '0;
      x1           <= '0;
      x2           <= '0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      state        <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (sample_valid) begin
            x2     <= x1;
            x1     <= x0;
            x0     <= sample_in;
            coef_q <= coeffs;
            acc    <= '0;
            state  <= MAC0;
          end
        end
        MAC0: begin
          acc   <= acc_next;
          state <= MAC1;
        end
        MAC1: begin
          acc   <= acc_next;
          state <= MAC2;
        end
        MAC2: begin
          acc          <= acc_next;
          result       <= acc_next;
          result_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          // Handoff edge never accepts; sample_ready rises the following cycle.
          if (out_ready) begin
            result_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
